// File: rtl/bitmap_scanline_reader.sv
// Fetches one 1bpp bitmap scanline per line_start and serializes it into a per-pixel stream.
// Define BITMAP_CLEAR_ON_READ_EN to zero each word in RAM the cycle after its read data returns.
module bitmap_scanline_reader #(
  parameter int unsigned ADDRESS_LENGTH = 14,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned WORDS_PER_LINE = 24,
  parameter int unsigned LINES          = 576
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      frame_start,
  input  logic                      line_start,
  input  logic                      pixel_en,
  output logic                      mem_rd_en,
  output logic [ADDRESS_LENGTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0]     mem_rd_data,
  output logic                      mem_wr_en,
  output logic [DATA_WIDTH-1:0]     mem_wr_data,
  output logic                      pixel_on,
  output logic                      pixel_valid,
  output logic                      line_done,
  output logic                      underrun
);

  localparam int unsigned PIX_PER_LINE = WORDS_PER_LINE * DATA_WIDTH;
  localparam int unsigned ROW_W        = $clog2(LINES + 1);
  localparam int unsigned COL_W        = $clog2(PIX_PER_LINE);
  localparam int unsigned IDX_W        = $clog2(WORDS_PER_LINE + 1);
  localparam int unsigned CNT_W        = $clog2(DATA_WIDTH + 1);
`ifdef BITMAP_CLEAR_ON_READ_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_DONE} state_e;

  state_e                    state_q, state_d;
  logic [ROW_W-1:0]          row_q, row_d;
  logic [ADDRESS_LENGTH-1:0] base_q, base_d;
  logic [IDX_W-1:0]          word_idx_q, word_idx_d;
  logic [COL_W-1:0]          col_q, col_d;
  logic [DATA_WIDTH-1:0]     sh_q, sh_d;
  logic [CNT_W-1:0]          sh_cnt_q, sh_cnt_d;
  logic [DATA_WIDTH-1:0]     nx_q, nx_d;
  logic                      nx_full_q, nx_full_d;
  logic                      rd_pend_q, rd_pend_d;
  logic [ADDRESS_LENGTH-1:0] pend_addr_q, pend_addr_d;
  logic                      mem_rd_en_q, mem_rd_en_d;
  logic [ADDRESS_LENGTH-1:0] mem_addr_q, mem_addr_d;
  logic                      mem_wr_en_q, mem_wr_en_d;
  logic                      pixel_on_q, pixel_on_d;
  logic                      pixel_valid_q, pixel_valid_d;
  logic                      line_done_q, line_done_d;
  logic                      underrun_q, underrun_d;

  logic       is_active, sh_full, consume, line_end, start_line, data_accept;
  logic [2:0] occupancy;

  assign is_active   = (state_q == ST_ACTIVE);
  assign sh_full     = (sh_cnt_q != '0);
  assign consume     = is_active && pixel_en && sh_full && !frame_start;
  assign line_end    = consume && (col_q == COL_W'(PIX_PER_LINE - 1));
  assign start_line  = (state_q == ST_IDLE) && line_start && !frame_start && (row_q != ROW_W'(LINES));
  // A word returning after the line has ended (or was aborted) is dropped.
  assign data_accept = is_active && rd_pend_q && !frame_start && !line_end;
  assign occupancy   = 3'(sh_full) + 3'(nx_full_q) + 3'(mem_rd_en_q) + 3'(rd_pend_q);

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (frame_start) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (line_start) state_d = (row_q == ROW_W'(LINES)) ? ST_DONE : ST_ACTIVE;
        ST_ACTIVE: if (line_end) state_d = ST_IDLE;
        ST_DONE:   state_d = ST_DONE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Fetch, buffering, serialization and output next-values
  always_comb begin
    row_d         = row_q;
    base_d        = base_q;
    word_idx_d    = word_idx_q;
    col_d         = col_q;
    sh_d          = sh_q;
    sh_cnt_d      = sh_cnt_q;
    nx_d          = nx_q;
    nx_full_d     = nx_full_q;
    rd_pend_d     = mem_rd_en_q;
    pend_addr_d   = mem_rd_en_q ? mem_addr_q : pend_addr_q;
    mem_rd_en_d   = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wr_en_d   = 1'b0;
    pixel_on_d    = 1'b0;
    pixel_valid_d = 1'b0;
    line_done_d   = 1'b0;
    underrun_d    = underrun_q;

    if (consume) begin
      pixel_on_d    = sh_q[0];
      pixel_valid_d = 1'b1;
      col_d         = col_q + COL_W'(1);
      if (sh_cnt_q == CNT_W'(1) && nx_full_q) begin
        sh_d      = nx_q;
        sh_cnt_d  = CNT_W'(DATA_WIDTH);
        nx_full_d = 1'b0;
      end else begin
        sh_d     = sh_q >> 1;
        sh_cnt_d = sh_cnt_q - CNT_W'(1);
      end
    end else if (is_active && pixel_en && !frame_start) begin
      pixel_valid_d = 1'b1;
      underrun_d    = 1'b1;
    end

    if (data_accept) begin
      if (sh_cnt_d == '0) begin
        sh_d     = mem_rd_data;
        sh_cnt_d = CNT_W'(DATA_WIDTH);
      end else begin
        nx_d      = mem_rd_data;
        nx_full_d = 1'b1;
      end
      mem_wr_en_d = CLEAR_EN;
      if (CLEAR_EN) mem_addr_d = pend_addr_q;
    end

    // The address port is shared, so a clear-write cycle stalls the read.
    if (start_line) begin
      mem_rd_en_d = 1'b1;
      mem_addr_d  = base_q;
      word_idx_d  = IDX_W'(1);
      col_d       = '0;
      sh_cnt_d    = '0;
      nx_full_d   = 1'b0;
    end else if (is_active && !frame_start && !line_end && !mem_wr_en_d &&
                 (word_idx_q < IDX_W'(WORDS_PER_LINE)) && (occupancy < 3'd2)) begin
      mem_rd_en_d = 1'b1;
      mem_addr_d  = base_q + ADDRESS_LENGTH'(word_idx_q);
      word_idx_d  = word_idx_q + IDX_W'(1);
    end

    if (line_end) begin
      line_done_d = 1'b1;
      row_d       = row_q + ROW_W'(1);
      base_d      = base_q + ADDRESS_LENGTH'(WORDS_PER_LINE);
      sh_cnt_d    = '0;
      nx_full_d   = 1'b0;
    end

    if (frame_start) begin
      row_d         = '0;
      base_d        = '0;
      word_idx_d    = '0;
      col_d         = '0;
      sh_cnt_d      = '0;
      nx_full_d     = 1'b0;
      mem_rd_en_d   = 1'b0;
      mem_wr_en_d   = 1'b0;
      pixel_valid_d = 1'b0;
      pixel_on_d    = 1'b0;
      line_done_d   = 1'b0;
      underrun_d    = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      row_q         <= '0;
      base_q        <= '0;
      word_idx_q    <= '0;
      col_q         <= '0;
      sh_q          <= '0;
      sh_cnt_q      <= '0;
      nx_q          <= '0;
      nx_full_q     <= 1'b0;
      rd_pend_q     <= 1'b0;
      pend_addr_q   <= '0;
      mem_rd_en_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_en_q   <= 1'b0;
      pixel_on_q    <= 1'b0;
      pixel_valid_q <= 1'b0;
      line_done_q   <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      row_q         <= row_d;
      base_q        <= base_d;
      word_idx_q    <= word_idx_d;
      col_q         <= col_d;
      sh_q          <= sh_d;
      sh_cnt_q      <= sh_cnt_d;
      nx_q          <= nx_d;
      nx_full_q     <= nx_full_d;
      rd_pend_q     <= rd_pend_d;
      pend_addr_q   <= pend_addr_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_en_q   <= mem_wr_en_d;
      pixel_on_q    <= pixel_on_d;
      pixel_valid_q <= pixel_valid_d;
      line_done_q   <= line_done_d;
      underrun_q    <= underrun_d;
    end
  end

  assign mem_rd_en   = mem_rd_en_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wr_en   = mem_wr_en_q;
  assign mem_wr_data = '0;
  assign pixel_on    = pixel_on_q;
  assign pixel_valid = pixel_valid_q;
  assign line_done   = line_done_q;
  assign underrun    = underrun_q;

endmodule

// File: doc/bitmap_scanline_reader.md
# bitmap_scanline_reader

Reads the 1-bit-per-pixel waveform bitmap (24 × 32-bit words per line, 576 lines) from the dual-port bitmap RAM, one scanline at a time. It serializes each word into a per-pixel on/off stream for the VGA pixel pipeline. It is the consumer side of the bitmap whose bits are set by the mono-sample address translator; word/bit mapping matches that writer exactly.

## Interface
- ADDRESS_LENGTH, 14, bitmap word address width
- DATA_WIDTH, 32, bitmap word width (pixels per word)
- WORDS_PER_LINE, 24, words per scanline (768 pixels)
- LINES, 576, scanlines per frame
- clk  in  1  system clock
- resetn  in  1  synchronous, active-low reset
- frame_start  in  1  one-cycle pulse at VSYNC; restarts at line 0
- line_start  in  1  one-cycle pulse requesting the next scanline
- pixel_en  in  1  consume one pixel this cycle
- mem_rd_en  out  1  bitmap read strobe
- mem_addr  out  ADDRESS_LENGTH  bitmap address (read and clear-write)
- mem_rd_data  in  DATA_WIDTH  read data, valid the cycle after mem_rd_en
- mem_wr_en  out  1  clear-write strobe
- mem_wr_data  out  DATA_WIDTH  always 0
- pixel_on  out  1  current pixel lit
- pixel_valid  out  1  pixel_on is meaningful
- line_done  out  1  one-cycle pulse after the last pixel of a line
- underrun  out  1  sticky: pixel_en arrived with no bit available; cleared by frame_start

## Operation
- Reset values:
  - all outputs 0.
  - row = 0, base = 0, FSM = IDLE.
  - shifter and next_word buffers empty.
- Mapping: pixel column c of row r is bit (c % 32) of word r*WORDS_PER_LINE + (c >> 5). Bit 0 is the leftmost pixel of the word.
- FSM IDLE:
  - line_start with row < LINES → ACTIVE, word_idx = 0.
  - line_start with row == LINES → DONE.
- FSM ACTIVE, fetching:
  - Two word slots: shifter and next_word.
  - A read issues (mem_rd_en = 1, mem_addr = base + word_idx, word_idx++) when word_idx < WORDS_PER_LINE and fewer than 2 words are buffered or in flight.
  - Returned data goes into the shifter if it is empty, else into next_word.
- FSM ACTIVE, shifting:
  - pixel_en with bits available: pixel_on ← shifter[0], pixel_valid ← 1, shifter shifts right.
  - After the 32nd bit, the shifter reloads from next_word in the same cycle if next_word is full.
- Underrun: pixel_en in ACTIVE with the shifter empty gives pixel_on ← 0, pixel_valid ← 1, underrun ← 1.
- End of line:
  - After 768 consumed pixels: line_done pulses, row++, base += WORDS_PER_LINE, FSM → IDLE.
  - Any word still in flight is discarded.
- FSM DONE: ignores line_start until frame_start.
- Outside ACTIVE: pixel_en gives pixel_valid = 0, pixel_on = 0, no underrun.
- line_start while ACTIVE is ignored.
- frame_start in any state:
  - aborts the line, empties buffers, clears underrun;
  - row = 0, base = 0, FSM → IDLE;
  - takes priority over a simultaneous line_start (that line_start is dropped).
- resetn low mid-line returns everything to reset values on the next edge.

## Timing
- RAM read latency: exactly 1 cycle. mem_rd_en and mem_addr are registered outputs.
- line_start sampled at edge T:
  - mem_rd_en = 1 during T+1;
  - data returns in T+2 and is in the shifter from T+3.
- pixel_en is permitted from T+3 onward.
- Continuous pixel_en from T+3 for 768 cycles never underruns.
- pixel_on and pixel_valid are registered: 1 cycle after the pixel_en that consumed the bit.
- line_done is asserted in the same cycle as the 768th pixel_valid.
- No read is issued in a cycle where mem_wr_en = 1; the shared address port is never contended.

## Configuration
- Macro: BITMAP_CLEAR_ON_READ_EN.
- Defined:
  - In the cycle a read's data returns, the next cycle drives mem_wr_en = 1, mem_addr = that read's address, mem_wr_data = 0.
  - Every word is erased after display, so each frame shows only samples written since the previous scan.
  - Reads are stalled for that cycle.
  - First-pixel latency is unchanged (T+3). Continuous pixel_en still never underruns.
- Undefined:
  - mem_wr_en is tied to 0; the bitmap persists until cleared externally.
  - Reads may issue back-to-back.

## Test plan
- Reset, then frame_start and line_start with row 0 word 0 = 0x0000_0005 and other words 0, continuous pixel_en from T+3 → pixel_on = 1,0,1 then 765 zeros; line_done on the 768th pixel_valid; underrun = 0.
- Row 1 word 23 = 0x8000_0000, two lines requested → second line has pixel_on = 1 only at column 767; mem_addr sweeps 24..47.
- pixel_en asserted at T+2 (one cycle early) → pixel_valid = 1, pixel_on = 0, underrun = 1; underrun stays 1 until frame_start.
- frame_start mid-line (column 300), then line_start → the restarted line reads from address 0; no line_done for the aborted line.
- 577 line_start pulses → only 576 line_done pulses; the last accepted line reads addresses 13800..13823.
- Built with BITMAP_CLEAR_ON_READ_EN: after a full line, each of addresses 0..23 has seen exactly one mem_wr_en with data 0, the cycle after its read data returned; a second frame reads all zeros.
